// File: rtl/sel_mux_rr.sv
// sel_mux_rr: registered NUM_CH-channel, WIDTH-bit selector with per-channel
// valid/ready handshakes and a single output slot. MODE 0 takes the channel
// named by sel; MODE 1 arbitrates round-robin starting from an internal pointer
// that moves past each granted channel.
module sel_mux_rr #(
   parameter int  WIDTH  = 8,
   parameter int  NUM_CH = 4,
   parameter int  MODE   = 0,
   localparam int SELW   = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic [SELW-1:0]         sel,
   output logic [WIDTH-1:0]        out_data,
   output logic [SELW-1:0]         out_ch,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [SELW-1:0]   ptr_r;
   logic [SELW-1:0]   ptr_nxt_s;
   logic [SELW-1:0]   g_s;
   logic              grant_vld_s;
   logic              can_load_s;
   logic              xfer_s;
   logic [NUM_CH-1:0] in_ready_s;
   logic [WIDTH-1:0]  sel_data_s;
   logic [WIDTH-1:0]  out_data_r;
   logic [SELW-1:0]   out_ch_r;
   logic              out_valid_r;

   // Channel index reached by stepping off positions forward from base, wrapping.
   function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] base, input int off);
      return SELW'((int'(base) + off) % NUM_CH);
   endfunction

   // Grant: external select in MODE 0, first valid channel from ptr upward in MODE 1.
   always_comb begin
      g_s         = {SELW{1'b0}};
      grant_vld_s = 1'b0;
      if (MODE == 1) begin
         // Walk offsets from farthest to nearest so the nearest valid channel wins.
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (in_valid[rr_idx(ptr_r, k)]) begin
               g_s         = rr_idx(ptr_r, k);
               grant_vld_s = 1'b1;
            end else begin
               g_s         = g_s;
               grant_vld_s = grant_vld_s;
            end
         end
      end else begin
         g_s = sel;
         // An out-of-range sel matches no channel and therefore never grants.
         for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SELW'(i)) begin
               grant_vld_s = in_valid[i];
            end else begin
               grant_vld_s = grant_vld_s;
            end
         end
      end
   end

   // Data mux for the granted channel; feeds only the output register.
   always_comb begin
      sel_data_s = {WIDTH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         if (g_s == SELW'(i)) begin
            sel_data_s = in_data[i*WIDTH +: WIDTH];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
   end

   // Handshake: one-hot ready toward the granted channel when the slot can take a beat.
   always_comb begin
      in_ready_s = {NUM_CH{1'b0}};
      can_load_s = ~out_valid_r | out_ready;
      for (int i = 0; i < NUM_CH; i++) begin
         in_ready_s[i] = rst_n & can_load_s & grant_vld_s & (g_s == SELW'(i));
      end
      xfer_s    = |(in_valid & in_ready_s);
      ptr_nxt_s = (g_s == SELW'(NUM_CH - 1)) ? {SELW{1'b0}} : (g_s + SELW'(1'b1));
   end

   // Output slot: load on input transfer, empty on a lone output transfer, else hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_r  <= {WIDTH{1'b0}};
         out_ch_r    <= {SELW{1'b0}};
         out_valid_r <= 1'b0;
      end else if (xfer_s) begin
         out_data_r  <= sel_data_s;
         out_ch_r    <= g_s;
         out_valid_r <= 1'b1;
      end else if (out_ready) begin
         out_data_r  <= out_data_r;
         out_ch_r    <= out_ch_r;
         out_valid_r <= 1'b0;
      end else begin
         out_data_r  <= out_data_r;
         out_ch_r    <= out_ch_r;
         out_valid_r <= out_valid_r;
      end
   end

   // Round-robin pointer: moves past the granted channel only on an input transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_r <= {SELW{1'b0}};
      end else if (xfer_s && (MODE == 1)) begin
         ptr_r <= ptr_nxt_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_data  = out_data_r;
   assign out_ch    = out_ch_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sel_mux_rr.sv
// Bench for sel_mux_rr: three instances (MODE 0 with 4 and 3 channels, MODE 1
// with 4 channels). Stimulus pushes expected {out_ch, out_data} beats into
// per-instance queues; monitors pop and compare on every output transfer.
module tb_sel_mux_rr;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   // Free-running clock
   always #5 clk = ~clk;

   logic [31:0] a_data;  logic [3:0] a_valid, a_ready;  logic [1:0] a_sel, a_och;
   logic [7:0]  a_od;    logic a_ov, a_or;
   logic [23:0] b_data;  logic [2:0] b_valid, b_ready;  logic [1:0] b_sel, b_och;
   logic [7:0]  b_od;    logic b_ov, b_or;
   logic [31:0] c_data;  logic [3:0] c_valid, c_ready;  logic [1:0] c_sel, c_och;
   logic [7:0]  c_od;    logic c_ov, c_or;

   logic [9:0] q_a[$];
   logic [9:0] q_b[$];
   logic [9:0] q_c[$];

   sel_mux_rr #(.WIDTH(8), .NUM_CH(4), .MODE(0)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
      .sel(a_sel), .out_data(a_od), .out_ch(a_och), .out_valid(a_ov), .out_ready(a_or));

   sel_mux_rr #(.WIDTH(8), .NUM_CH(3), .MODE(0)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
      .sel(b_sel), .out_data(b_od), .out_ch(b_och), .out_valid(b_ov), .out_ready(b_or));

   sel_mux_rr #(.WIDTH(8), .NUM_CH(4), .MODE(1)) u_c (
      .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
      .sel(c_sel), .out_data(c_od), .out_ch(c_och), .out_valid(c_ov), .out_ready(c_or));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor for instance a: every output transfer must match the next expected beat
   always @(negedge clk) begin
      if (a_ov && a_or) begin
         if (q_a.size() == 0) chk("a_unexpected_beat", {22'd0, a_och, a_od}, 32'hFFFF_FFFF);
         else chk("a_beat", {22'd0, a_och, a_od}, {22'd0, q_a.pop_front()});
      end
   end

   // Monitor for instance b
   always @(negedge clk) begin
      if (b_ov && b_or) begin
         if (q_b.size() == 0) chk("b_unexpected_beat", {22'd0, b_och, b_od}, 32'hFFFF_FFFF);
         else chk("b_beat", {22'd0, b_och, b_od}, {22'd0, q_b.pop_front()});
      end
   end

   // Monitor for instance c
   always @(negedge clk) begin
      if (c_ov && c_or) begin
         if (q_c.size() == 0) chk("c_unexpected_beat", {22'd0, c_och, c_od}, 32'hFFFF_FFFF);
         else chk("c_beat", {22'd0, c_och, c_od}, {22'd0, q_c.pop_front()});
      end
   end

   initial begin
      logic [7:0] d;
      logic       mov;
      logic [3:0] er;
      logic [1:0] ch;

      // ---------------- reset with every channel valid ----------------
      rst_n   = 1'b0;
      a_data  = {8'h44, 8'h33, 8'h22, 8'h11}; a_valid = 4'hF; a_sel = 2'd0; a_or = 1'b1;
      b_data  = {8'h66, 8'h55, 8'h44};        b_valid = 3'h7; b_sel = 2'd0; b_or = 1'b1;
      c_data  = {8'h44, 8'h33, 8'h22, 8'h11}; c_valid = 4'hF; c_sel = 2'd0; c_or = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("rst_a_ov", a_ov, 32'd0);
         chk("rst_a_od", a_od, 32'd0);
         chk("rst_a_och", a_och, 32'd0);
         chk("rst_a_ready", a_ready, 32'd0);
         chk("rst_c_ready", c_ready, 32'd0);
         chk("rst_c_ov", c_ov, 32'd0);
      end
      step();
      rst_n = 1'b1; a_valid = 4'h0; b_valid = 3'h0; c_valid = 4'h0;
      @(negedge clk);
      step();

      // ---------------- MODE 0: select, stall, drain ----------------
      a_valid = 4'hF; a_sel = 2'd2; a_or = 1'b1;
      @(negedge clk);
      chk("a_sel2_ready", a_ready, 32'b0100);
      q_a.push_back({2'd2, 8'h33});
      step();
      a_or = 1'b0;
      @(negedge clk);
      chk("a_stall_ready", a_ready, 32'd0);
      chk("a_stall_ov", a_ov, 32'd1);
      chk("a_stall_od", a_od, 32'h33);
      chk("a_stall_och", a_och, 32'd2);
      step();
      @(negedge clk);
      chk("a_stall2_od", a_od, 32'h33);
      chk("a_stall2_ready", a_ready, 32'd0);
      step();
      a_or = 1'b1; a_valid = 4'h0;
      @(negedge clk);
      chk("a_drain_ready", a_ready, 32'd0);
      step();
      a_valid = 4'hF; a_sel = 2'd0;
      @(negedge clk);
      chk("a_empty_ov", a_ov, 32'd0);
      chk("a_sel0_ready", a_ready, 32'b0001);
      q_a.push_back({2'd0, 8'h11});
      step();
      a_sel = 2'd3;
      @(negedge clk);
      chk("a_sel3_ready", a_ready, 32'b1000);
      q_a.push_back({2'd3, 8'h44});
      step();
      a_valid = 4'b1101; a_sel = 2'd1;
      @(negedge clk);
      chk("a_sel_invalid_ready", a_ready, 32'd0);
      step();
      a_valid = 4'h0;
      @(negedge clk);
      chk("a_final_ov", a_ov, 32'd0);
      step();

      // ---------------- MODE 0, 3 channels: out-of-range select ----------------
      b_valid = 3'h7; b_sel = 2'd1; b_or = 1'b1;
      @(negedge clk);
      chk("b_sel1_ready", b_ready, 32'b010);
      q_b.push_back({2'd1, 8'h55});
      step();
      b_sel = 2'd3;
      @(negedge clk);
      chk("b_oor_ready", b_ready, 32'd0);
      chk("b_oor_ov_before", b_ov, 32'd1);
      step();
      @(negedge clk);
      chk("b_oor_ov_after", b_ov, 32'd0);
      chk("b_oor_ready2", b_ready, 32'd0);
      step();
      b_valid = 3'h0;

      // ---------------- MODE 1: fairness with all channels valid ----------------
      c_valid = 4'hF; c_or = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ch = 2'(i % 4);
         @(negedge clk);
         chk("c_fair_ready", c_ready, 32'(4'b0001 << ch));
         if (i > 0) chk("c_fair_ov", c_ov, 32'd1);
         q_c.push_back({ch, 8'(8'h11 * (ch + 1))});
         step();
      end
      c_valid = 4'h0;
      @(negedge clk);
      step();

      // ---------------- MODE 1: sparse channels and wrap ----------------
      c_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         ch = (i % 2 == 0) ? 2'd1 : 2'd3;
         @(negedge clk);
         chk("c_sparse_ready", c_ready, 32'(4'b0001 << ch));
         q_c.push_back({ch, 8'(8'h11 * (ch + 1))});
         step();
      end
      c_valid = 4'b0001;
      @(negedge clk);
      chk("c_wrap_ready", c_ready, 32'b0001);
      q_c.push_back({2'd0, 8'h11});
      step();
      c_valid = 4'h0;
      @(negedge clk);
      step();

      // ---------------- MODE 1: back-pressure with incrementing data ----------------
      d   = 8'h80;
      mov = 1'b0;
      for (int i = 0; i < 10; i++) begin
         c_or         = (i % 2 == 0);
         c_valid      = 4'b0001;
         c_data[7:0]  = d;
         @(negedge clk);
         er = (!mov || c_or) ? 4'b0001 : 4'b0000;
         chk("c_bp_ready", c_ready, 32'(er));
         if (er != 4'b0000) begin
            q_c.push_back({2'd0, d});
            d   = d + 8'd1;
            mov = 1'b1;
         end else begin
            chk("c_bp_ptr_hold", u_c.ptr_r, 32'd1);
         end
         step();
      end
      c_or = 1'b1; c_valid = 4'h0; c_data = {8'h44, 8'h33, 8'h22, 8'h11};
      @(negedge clk);
      step();

      // ---------------- MODE 1: reset mid-stream ----------------
      c_valid = 4'b0010; c_or = 1'b1;
      @(negedge clk);
      chk("c_pre_rst_ready", c_ready, 32'b0010);
      q_c.push_back({2'd1, 8'h22});
      step();
      c_valid = 4'h0; c_or = 1'b0;
      @(negedge clk);
      chk("c_held_ov", c_ov, 32'd1);
      chk("c_held_ptr", u_c.ptr_r, 32'd2);
      step();
      rst_n = 1'b0; c_valid = 4'b1110;
      @(negedge clk);
      chk("c_rst_ready", c_ready, 32'd0);
      step();
      q_c.delete();
      rst_n = 1'b1; c_or = 1'b1;
      @(negedge clk);
      chk("c_post_rst_ov", c_ov, 32'd0);
      chk("c_post_rst_ready", c_ready, 32'b0010);
      q_c.push_back({2'd1, 8'h22});
      step();
      c_valid = 4'h0;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("c_end_ov", c_ov, 32'd0);

      chk("q_a_empty", q_a.size(), 32'd0);
      chk("q_b_empty", q_b.size(), 32'd0);
      chk("q_c_empty", q_c.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sel_mux_rr.md
# sel_mux_rr

Parametrised, registered N-channel, W-bit selector for the carry-select adder/subtractor datapath. It generalises the 2:1 one-bit select mux to NUM_CH input channels of WIDTH bits, each with a valid/ready handshake. It supports two modes: external select, or round-robin arbitration. The output is one registered stage feeding the downstream adder pipeline.

## Interface
- WIDTH, 8: data width per channel (>=1).
- NUM_CH, 4: number of input channels (>=2).
- MODE, 0: 0 = external select via `sel`; 1 = round-robin arbitration (`sel` ignored).
- SELW, $clog2(NUM_CH): select/channel-index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready; at most one bit high per cycle.
- sel  in  SELW  channel select in MODE 0.
- out_data  out  WIDTH  registered selected data.
- out_ch  out  SELW  index of the channel that produced out_data.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts the beat.

## Operation
- Single output register slot: out_data, out_ch, out_valid.
- can_load = ~out_valid | out_ready.
- Grant, MODE 0:
  - g = sel; grant_vld = (sel < NUM_CH) & in_valid[sel].
  - sel >= NUM_CH: no grant, and all in_ready are 0.
- Grant, MODE 1:
  - Search starts at ptr, then ptr+1, …, wrapping modulo NUM_CH.
  - g = first index with in_valid set; grant_vld = |in_valid.
- in_ready[i] = can_load & grant_vld & (i == g). It is combinational and depends on in_valid, sel, ptr, out_valid and out_ready.
- Input transfer on channel g when in_valid[g] & in_ready[g]. On that edge:
  - out_data <= in_data[g]; out_ch <= g; out_valid <= 1.
  - MODE 1 only: ptr <= (g == NUM_CH-1) ? 0 : g+1.
- Output transfer when out_valid & out_ready:
  - If no input transfer occurs on the same edge, out_valid <= 0, and out_data/out_ch hold their last values.
  - A simultaneous output and input transfer refills the slot in the same cycle. Full throughput is 1 beat/cycle.
- out_valid & ~out_ready: out_data, out_ch and out_valid hold; all in_ready are 0; ptr holds.
- ptr advances only on an input transfer, never on idle or stalled cycles. It is unused in MODE 0.
- Data is passed unmodified; no arithmetic. Width is exactly WIDTH bits.

## Timing
- Latency: 1 cycle. An input transfer at edge k gives out_valid=1 with that data after edge k.
- Reset (rst_n low at a rising edge):
  - out_valid=0, out_data=0, out_ch=0, ptr=0.
  - in_ready is all 0 while rst_n is low, regardless of can_load.
- Reset mid-operation: a held beat is discarded, no handshake completes on the reset edge, and the round-robin pointer returns to 0.
- First edge after rst_n goes high: normal operation. An input that is valid at that edge may transfer.
- Simultaneous events:
  - Output drain plus input load on one edge: the new beat wins, and out_valid stays 1.
  - Multiple valid channels in MODE 1: exactly one is granted (priority from ptr upward, wrapping).
- MODE 0 `sel` may change every cycle; it is sampled combinationally at each edge, with no hysteresis.
- No combinational path from in_data to any output port.

## Test plan
- Reset: drive all in_valid=1 with rst_n=0 for 3 cycles. Required: out_valid=0, out_data=0, out_ch=0, in_ready=0 throughout.
- MODE 0 select and stall (WIDTH=8, NUM_CH=4):
  - Drive in_data={8'h44,8'h33,8'h22,8'h11} with all valid, sel=2, and out_ready=1. Required: in_ready=4'b0100, and out_data=8'h33, out_ch=2 one cycle later.
  - Drop out_ready to 0. Required: output holds 8'h33 and in_ready=0.
  - Drive sel=3'b… out of range (NUM_CH=3 build, sel=3). Required: in_ready=0 and out_valid falls after the drain.
- MODE 1 fairness: hold all 4 channels valid with out_ready=1 for 8 cycles. Required: out_ch sequence 0,1,2,3,0,1,2,3, with one beat every cycle.
- MODE 1 sparse/wrap: only channels 1 and 3 valid, ptr starting at 0. Required: out_ch 1,3,1,3. Then with only channel 0 valid after ch 3 is granted, required: ch 0 granted immediately (wrap).
- Back-pressure throughput: toggle out_ready 1,0,1,0 with channel 0 continuously valid, data incrementing per accepted beat. Required: no beat lost or duplicated, out_data increments by exactly 1 per output transfer, and ptr is unchanged during stall cycles.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and ptr=2, then release. Required: out_valid=0 after the reset edge, and the next MODE 1 grant goes to the lowest valid index starting from 0.
